// File: rtl/adc_avg_pulse.sv
// adc_avg_pulse: averages one round of N_CH A/D samples and emits the mean as a pulse of that many cycles.
// Optional ADC_AVG_ROUND_EN selects a round-half-up mean instead of truncation.
module adc_avg_pulse #(
    parameter int W = 8,
    parameter int N_CH_LOG2 = 1,
    localparam int N_CH = 2**N_CH_LOG2
) (
    input  logic              clock,
    input  logic              reset,
    output logic [N_CH-1:0]   soc,
    input  logic [N_CH-1:0]   eoc,
    input  logic [N_CH*W-1:0] x,
    output logic              out,
    output logic [W-1:0]      avg,
    output logic              avg_valid
);
`ifdef ADC_AVG_ROUND_EN
    localparam int SW = W + N_CH_LOG2 + 1;
    localparam logic [SW-1:0] RND = SW'(2**(N_CH_LOG2-1));
`else
    localparam int SW = W + N_CH_LOG2;
    localparam logic [SW-1:0] RND = '0;
`endif
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_CALC, S_PULSE} state_t;
    typedef enum logic [1:0] {P_REQ, P_WAIT, P_DONE} phase_t;
    state_t state;
    phase_t ph [N_CH];
    logic [W-1:0] smp [N_CH];
    logic [N_CH-1:0] done;
    logic [W-1:0] cnt;
    logic [SW-1:0] sum;
    logic [W-1:0] mean;
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) sum = sum + SW'(smp[i]);
        mean = W'((sum + RND) >> N_CH_LOG2);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            soc       <= '0;
            out       <= 1'b0;
            avg       <= '0;
            avg_valid <= 1'b0;
            done      <= '0;
            cnt       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ph[i]  <= P_REQ;
                smp[i] <= '0;
            end
        end else begin
            avg_valid <= 1'b0;
            case (state)
                S_IDLE: if (&eoc) begin
                    state <= S_CONV;
                    soc   <= '1;
                    done  <= '0;
                    for (int i = 0; i < N_CH; i++) ph[i] <= P_REQ;
                end
                S_CONV: begin
                    // each converter walks its own request/wait phases; skew is unbounded
                    for (int i = 0; i < N_CH; i++) begin
                        if (ph[i] == P_REQ && !eoc[i]) begin
                            soc[i] <= 1'b0;
                            ph[i]  <= P_WAIT;
                        end
                        if (ph[i] == P_WAIT && eoc[i]) begin
                            smp[i]  <= x[i*W +: W];
                            done[i] <= 1'b1;
                            ph[i]   <= P_DONE;
                        end
                    end
                    if (&done) state <= S_CALC;
                end
                S_CALC: begin
                    avg       <= mean;
                    avg_valid <= 1'b1;
                    cnt       <= mean;
                    out       <= mean != '0;
                    state     <= mean == '0 ? S_IDLE : S_PULSE;
                end
                S_PULSE: if (cnt == W'(1)) begin
                    out   <= 1'b0;
                    state <= S_IDLE;
                end else begin
                    cnt <= cnt - W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_avg_pulse.sv
// tb_adc_avg_pulse: two-channel and four-channel instances driven by behavioural converters, checked against a scoreboard.
module tb_adc_avg_pulse;
`ifdef ADC_AVG_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    logic [1:0] soc2, eoc2;
    logic [15:0] x2;
    logic out2, av2v;
    logic [7:0] avg2;
    logic [3:0] soc4, eoc4;
    logic [31:0] x4;
    logic out4, av4v;
    logic [7:0] avg4;
    int lat2 [2], lat4 [4];
    logic [7:0] val2 [2], val4 [4];
    int req2 = 0, req4 = 0;
    int errors = 0, checks = 0;
    int q2 [$], q4 [$];
    int pend2 = 0, pend4 = 0, w2 = 0, w4 = 0;

    adc_avg_pulse #(.W(8), .N_CH_LOG2(1)) dut2 (.clock(clock), .reset(reset), .soc(soc2), .eoc(eoc2),
        .x(x2), .out(out2), .avg(avg2), .avg_valid(av2v));
    adc_avg_pulse #(.W(8), .N_CH_LOG2(2)) dut4 (.clock(clock), .reset(reset), .soc(soc4), .eoc(eoc4),
        .x(x4), .out(out4), .avg(avg4), .avg_valid(av4v));

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // converters start only when the test grants another conversion, holding x garbage until eoc rises
    for (genvar g = 0; g < 2; g++) begin : cv2
        logic e = 1'b1;
        logic [7:0] xv = 8'd0;
        int st = 0, c = 0, taken = 0;
        assign eoc2[g] = e;
        assign x2[g*8 +: 8] = xv;
        always @(negedge clock) begin
            if (st == 0 && soc2[g] && e && taken < req2) begin
                taken++; st = 1; c = lat2[g]; xv = 8'($urandom);
            end else if (st == 1) begin
                if (c == 0) begin e = 1'b0; st = 2; c = lat2[g]; end else c--;
            end else if (st == 2) begin
                if (c == 0) begin xv = val2[g]; e = 1'b1; st = 0; end else c--;
            end
        end
    end
    for (genvar g = 0; g < 4; g++) begin : cv4
        logic e = 1'b1;
        logic [7:0] xv = 8'd0;
        int st = 0, c = 0, taken = 0;
        assign eoc4[g] = e;
        assign x4[g*8 +: 8] = xv;
        always @(negedge clock) begin
            if (st == 0 && soc4[g] && e && taken < req4) begin
                taken++; st = 1; c = lat4[g]; xv = 8'($urandom);
            end else if (st == 1) begin
                if (c == 0) begin e = 1'b0; st = 2; c = lat4[g]; end else c--;
            end else if (st == 2) begin
                if (c == 0) begin xv = val4[g]; e = 1'b1; st = 0; end else c--;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) w2 = 0;
        else begin
            if (av2v) begin
                chk("avg2_valid_expected", int'(q2.size() != 0), 1);
                if (q2.size() != 0) begin pend2 = q2.pop_front(); chk("avg2", avg2, pend2); end
            end
            if (out2) w2++;
            else if (w2 > 0) begin chk("width2", w2, pend2); w2 = 0; end
        end
    end
    always @(negedge clock) begin
        if (reset) w4 = 0;
        else begin
            if (av4v) begin
                chk("avg4_valid_expected", int'(q4.size() != 0), 1);
                if (q4.size() != 0) begin pend4 = q4.pop_front(); chk("avg4", avg4, pend4); end
            end
            if (out4) w4++;
            else if (w4 > 0) begin chk("width4", w4, pend4); w4 = 0; end
        end
    end

    task automatic wait_done2(int budget);
        int n = 0;
        do begin @(negedge clock); #1; n++; end
        while ((q2.size() != 0 || out2 || w2 != 0) && n < budget);
        if (n >= budget) begin errors++; checks++; $display("FAIL timeout2: got %0d cycles required fewer", n); end
    endtask
    task automatic wait_done4(int budget);
        int n = 0;
        do begin @(negedge clock); #1; n++; end
        while ((q4.size() != 0 || out4 || w4 != 0) && n < budget);
        if (n >= budget) begin errors++; checks++; $display("FAIL timeout4: got %0d cycles required fewer", n); end
    endtask

    typedef struct {int a; int b; int la; int lb; int m;} vec_t;
    vec_t tv [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{10, 20, 1, 2, 15};
        tv[1] = '{0, 0, 0, 1, 0};
        tv[2] = '{11, 22, 2, 0, RND ? 17 : 16};
        tv[3] = '{255, 254, 3, 1, RND ? 255 : 254};
        tv[4] = '{1, 2, 1, 1, RND ? 2 : 1};
        tv[5] = '{0, 1, 0, 0, RND ? 1 : 0};
        tv[6] = '{255, 255, 1, 4, 255};
        tv[7] = '{3, 4, 2, 2, RND ? 4 : 3};
        repeat (3) @(negedge clock);
        chk("rst_soc2", soc2, 0);
        chk("rst_out2", out2, 0);
        chk("rst_avg2", avg2, 0);
        chk("rst_soc4", soc4, 0);
        reset = 1'b0;
        #1 chk("soc2_before_edge", soc2, 0);
        @(posedge clock); #1;
        chk("soc2_first_edge", soc2, 3);
        chk("soc4_first_edge", soc4, 15);
        for (int i = 0; i < 8; i++) begin
            val2[0] = 8'(tv[i].a); val2[1] = 8'(tv[i].b);
            lat2[0] = tv[i].la; lat2[1] = tv[i].lb;
            q2.push_back(tv[i].m);
            req2++;
            wait_done2(3000);
            if (tv[i].m == 0) begin
                int k = 0;
                while (soc2 != 2'b11 && k < 3) begin @(negedge clock); #1; k++; end
                chk("soc2_restart", soc2, 3);
            end
        end
        for (int i = 0; i < 4; i++) val4[i] = 8'd255;
        lat4[0] = 1; lat4[1] = 2; lat4[2] = 3; lat4[3] = 20;
        q4.push_back(255);
        req4++;
        repeat (10) @(negedge clock);
        #1 chk("soc4_skew", soc4, 8);
        wait_done4(3000);
        val2[0] = 30; val2[1] = 30; lat2[0] = 1; lat2[1] = 1;
        q2.push_back(30);
        req2++;
        begin
            int n = 0;
            do begin @(negedge clock); #1; n++; end while (!av2v && n < 500);
            chk("avg2_valid_seen", av2v, 1);
        end
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("out2_async_reset", out2, 0);
        chk("avg2_async_reset", avg2, 0);
        chk("soc2_async_reset", soc2, 0);
        @(negedge clock); #1 reset = 1'b0;
        repeat (3) begin @(negedge clock); #1 chk("out2_no_residual", out2, 0); end
        q2.push_back(30);
        req2++;
        wait_done2(3000);
        chk("avg2_after_reset", avg2, 30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_avg_pulse.md
Name: adc_avg_pulse

Overview:
- N-channel successor of the two-converter averaging block.
- Runs continuous conversion rounds over N_CH = 2**N_CH_LOG2 A/D converters using the soc/eoc handshake.
- Averages the captured samples and emits the mean as a single high pulse on out, lasting exactly that many clock cycles.
- Sits between the A/D converter bank and downstream pulse-width consumers; also exposes the mean as a registered value.

Parameters:
- W, 8, sample width per channel.
- N_CH_LOG2, 1, log2 of channel count. N_CH = 2**N_CH_LOG2; legal range 1..3.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- soc  out  N_CH  start-of-conversion, one bit per converter.
- eoc  in  N_CH  end-of-conversion, one bit per converter; idle high.
- x  in  N_CH*W  samples; channel i is x[i*W +: W].
- out  out  1  result pulse; high for exactly avg cycles.
- avg  out  W  mean of the last completed round, registered.
- avg_valid  out  1  one-cycle strobe when avg updates.

Behaviour:
- Reset, asynchronous, takes effect immediately: soc=0, out=0, avg=0, avg_valid=0, all done flags cleared, FSM=S_IDLE.
- S_IDLE: wait until every eoc bit is 1, then go to S_CONV. soc[i] is set to 1 on that same edge.
- S_CONV, per-channel sub-handshake with an independent 2-bit phase per channel:
  - P_REQ: soc[i]=1 until eoc[i]=0 is sampled, then soc[i]<=0.
  - P_WAIT: wait for eoc[i]=1, then capture x_i into sample register i and set done[i].
  - Channels progress independently; skew between converters is arbitrary.
  - soc[i] never re-asserts within a round.
- When all done[i]=1, go to S_CALC.
- S_CALC, one cycle:
  - sum is W+N_CH_LOG2 bits wide; no overflow.
  - mean = sum >> N_CH_LOG2, truncated.
  - Load avg, pulse avg_valid=1, load cnt=mean.
  - mean==0: go to S_IDLE. No out pulse.
  - Otherwise go to S_PULSE with out<=1.
- S_PULSE: out held at 1; cnt decrements each cycle. On the edge where cnt reaches 1, out<=0 and FSM goes to S_IDLE.
  - out high time = mean clock periods exactly; out is glitch-free (registered).
- Next round starts from S_IDLE, so rounds are back-to-back with a one-cycle-minimum gap.
- x sampled only on capture edges. x may be X at any other time.
- eoc[i] already 0 when soc[i] rises: handled as a normal P_REQ exit on the next edge.
- Reset asserted mid-conversion or mid-pulse: everything aborts immediately. The partial round is discarded and avg keeps its reset value 0.
- Maximum mean (2**W-1): pulse of 2**W-1 cycles; cnt must be W bits wide, no wrap.

Optional Feature:
- Macro ADC_AVG_ROUND_EN.
- Defined: mean = (sum + 2**(N_CH_LOG2-1)) >> N_CH_LOG2, i.e. round half up. Adder is widened by one bit so that 2**W-1 inputs still yield 2**W-1.
- Undefined: truncating mean as above. No extra logic.

Test Plan:
- Reset with all eoc=1: check soc=0, out=0, avg=0 during reset. soc=2'b11 exactly one edge after release.
- N_CH_LOG2=1, x0=10, x1=20, converters with latency 1 and 2 cycles: out high exactly 15 periods, avg=15, avg_valid once.
- x0=0, x1=0: avg_valid pulses with avg=0, out stays 0, and a new round's soc rises within 2 cycles.
- x0=11, x1=22: pulse of 16 cycles. With ADC_AVG_ROUND_EN: 17 cycles.
- N_CH_LOG2=2, all four x=255, channel 3 eoc delayed 20 cycles: soc[3] remains high until its eoc falls, and soc[0..2] drop independently. Result: pulse of 255 cycles, avg=255.
- reset pulsed at cycle 5 of a 30-cycle pulse: out falls asynchronously, and no residual pulse occurs. The next round completes normally with a correct width.
